// File: rtl/board_game_if.sv
// Pulse inputs and display-side status outputs of the K-in-a-row game engine.
interface board_game_if #(
  parameter int N       = 3,
  parameter int SCORE_W = 4
);
  localparam int CW = $clog2(N * N);

  logic               move_i;
  logic               select_i;
  logic               swap_i;
  logic               new_game_i;
  logic [CW-1:0]      cursor_o;
  logic [2*N*N-1:0]   board_o;
  logic               turn_o;
  logic               busy_o;
  logic               game_over_o;
  logic [1:0]         winner_o;
  logic               invalid_o;
  logic [SCORE_W-1:0] score1_o;
  logic [SCORE_W-1:0] score2_o;

  modport master (
    output move_i, select_i, swap_i, new_game_i,
    input  cursor_o, board_o, turn_o, busy_o, game_over_o, winner_o, invalid_o,
           score1_o, score2_o
  );

  modport slave (
    input  move_i, select_i, swap_i, new_game_i,
    output cursor_o, board_o, turn_o, busy_o, game_over_o, winner_o, invalid_o,
           score1_o, score2_o
  );
endinterface

// File: rtl/board_game_core.sv
// N x N two-player K-in-a-row engine; win check walks one direction per cycle.
// Win counters exist only when BOARD_GAME_SCORE_EN is defined.
module board_game_core #(
  parameter int N       = 3,
  parameter int WIN_LEN = 3,
  parameter int SCORE_W = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  board_game_if.slave bus
);
  localparam int CELLS = N * N;
  localparam int CW    = $clog2(CELLS);
  localparam int FW    = $clog2(CELLS + 1);

  typedef enum logic [1:0] {PLAY = 2'd0, CHECK = 2'd1, OVER = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [1:0]         dir_q, dir_d;
  logic [2*CELLS-1:0] board_q, board_d;
  logic [CW-1:0]      cursor_q, cursor_d;
  logic               turn_q, turn_d;
  logic               start_q, start_d;
  logic [1:0]         winner_q, winner_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               invalid_q, invalid_d;
  logic [1:0]         mark;
  logic               hit;
  int                 cur_idx;

  // Run through the placed cell along one direction, each side capped at WIN_LEN-1.
  function automatic logic line_hit(input logic [2*CELLS-1:0] b, input logic [CW-1:0] pos,
                                    input logic [1:0] dir, input logic [1:0] m);
    int   dr, dc, r, c, rr, cc, run, sg;
    logic go;
    dr  = (dir == 2'd0) ? 0 : 1;
    dc  = (dir == 2'd1) ? 0 : ((dir == 2'd3) ? -1 : 1);
    r   = int'(pos) / N;
    c   = int'(pos) % N;
    run = 1;
    for (int s = 0; s < 2; s++) begin
      sg = (s == 0) ? 1 : -1;
      go = 1'b1;
      for (int k = 1; k < WIN_LEN; k++) begin
        rr = r + sg * k * dr;
        cc = c + sg * k * dc;
        if (go && rr >= 0 && rr < N && cc >= 0 && cc < N) begin
          if (b[2*(rr*N+cc) +: 2] == m) run = run + 1;
          else go = 1'b0;
        end else begin
          go = 1'b0;
        end
      end
    end
    return (run >= WIN_LEN);
  endfunction

`ifdef BOARD_GAME_SCORE_EN
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
`endif

  assign mark    = {turn_q, ~turn_q};
  assign cur_idx = int'(cursor_q);
  assign hit     = line_hit(board_q, cursor_q, dir_q, mark);

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    board_d   = board_q;
    cursor_d  = cursor_q;
    turn_d    = turn_q;
    start_d   = start_q;
    winner_d  = winner_q;
    fill_d    = fill_q;
    invalid_d = 1'b0;
`ifdef BOARD_GAME_SCORE_EN
    score1_d  = score1_q;
    score2_d  = score2_q;
`endif
    if (bus.new_game_i) begin
      state_d  = PLAY;
      dir_d    = 2'd0;
      board_d  = '0;
      cursor_d = '0;
      fill_d   = '0;
      winner_d = 2'b00;
      start_d  = ~start_q;
      turn_d   = ~start_q;
    end else begin
      case (state_q)
        PLAY: begin
          if (bus.select_i) begin
            if (board_q[2*cur_idx +: 2] == 2'b00) begin
              board_d[2*cur_idx +: 2] = mark;
              fill_d  = fill_q + 1'b1;
              dir_d   = 2'd0;
              state_d = CHECK;
            end else begin
              invalid_d = 1'b1;
            end
          end else if (bus.swap_i) begin
            turn_d = ~turn_q;
          end else if (bus.move_i) begin
            cursor_d = (cursor_q == CW'(CELLS - 1)) ? '0 : cursor_q + 1'b1;
          end
        end
        CHECK: begin
          if (hit) begin
            winner_d = mark;
            state_d  = OVER;
`ifdef BOARD_GAME_SCORE_EN
            if (turn_q) score2_d = sat_inc(score2_q);
            else        score1_d = sat_inc(score1_q);
`endif
          end else if (dir_q == 2'd3) begin
            if (fill_q == FW'(CELLS)) begin
              winner_d = 2'b11;
              state_d  = OVER;
            end else begin
              turn_d  = ~turn_q;
              state_d = PLAY;
            end
          end else begin
            dir_d = dir_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= PLAY;
      dir_q     <= 2'd0;
      board_q   <= '0;
      cursor_q  <= '0;
      turn_q    <= 1'b0;
      start_q   <= 1'b0;
      winner_q  <= 2'b00;
      fill_q    <= '0;
      invalid_q <= 1'b0;
`ifdef BOARD_GAME_SCORE_EN
      score1_q  <= '0;
      score2_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      board_q   <= board_d;
      cursor_q  <= cursor_d;
      turn_q    <= turn_d;
      start_q   <= start_d;
      winner_q  <= winner_d;
      fill_q    <= fill_d;
      invalid_q <= invalid_d;
`ifdef BOARD_GAME_SCORE_EN
      score1_q  <= score1_d;
      score2_q  <= score2_d;
`endif
    end
  end

  assign bus.cursor_o    = cursor_q;
  assign bus.board_o     = board_q;
  assign bus.turn_o      = turn_q;
  assign bus.busy_o      = (state_q == CHECK);
  assign bus.game_over_o = (state_q == OVER);
  assign bus.winner_o    = winner_q;
  assign bus.invalid_o   = invalid_q;
`ifdef BOARD_GAME_SCORE_EN
  assign bus.score1_o    = score1_q;
  assign bus.score2_o    = score2_q;
`else
  assign bus.score1_o    = {SCORE_W{1'b0}};
  assign bus.score2_o    = {SCORE_W{1'b0}};
`endif
endmodule

// File: tb/tb_board_game_core.sv
// Bench for board_game_core: 3x3 and 4x4 instances driven from a vector table,
// expected per-cycle outputs queued at drive time and compared after each edge.
`timescale 1ns/1ps
module tb_board_game_core;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  board_game_if #(.N(3), .SCORE_W(4)) if3 ();
  board_game_if #(.N(4), .SCORE_W(1)) if4 ();

  board_game_core #(.N(3), .WIN_LEN(3), .SCORE_W(4)) u3 (.clk(clk), .reset_n(reset_n), .bus(if3));
  board_game_core #(.N(4), .WIN_LEN(3), .SCORE_W(1)) u4 (.clk(clk), .reset_n(reset_n), .bus(if4));

`ifdef BOARD_GAME_SCORE_EN
  localparam logic [3:0] SC1 = 4'd1;
`else
  localparam logic [3:0] SC1 = 4'd0;
`endif

  typedef struct {
    logic [31:0] board;
    logic [3:0]  cur;
    logic        turn, busy, over, inv;
    logic [1:0]  win;
    logic [3:0]  s1, s2;
  } snap_t;

  typedef enum {OP_SEL, OP_MOVE, OP_SWAP, OP_NEW, OP_IGN} op_t;

  // dec: 0..3 win decided in that direction, 4 no win, 5 draw, 6 occupied cell
  typedef struct {
    bit          d4;
    op_t         op;
    int          n;
    logic [31:0] board;
    logic        turn;
    logic [1:0]  win;
    int          dec;
    logic [3:0]  s1;
  } vec_t;

  snap_t exp_q[$];
  snap_t st[2];
  snap_t zero_s;
  vec_t  tbl[$];
  int    checks = 0;
  int    passes = 0;

  function automatic vec_t mk(bit d4, op_t op, int n, logic [31:0] b, logic t,
                              logic [1:0] w, int dec, logic [3:0] s1);
    vec_t v;
    v.d4 = d4; v.op = op; v.n = n; v.board = b; v.turn = t; v.win = w; v.dec = dec; v.s1 = s1;
    return v;
  endfunction

  function automatic snap_t grab(bit d4);
    snap_t s;
    if (d4) begin
      s.board = 32'(if4.board_o); s.cur = if4.cursor_o; s.turn = if4.turn_o;
      s.busy = if4.busy_o; s.over = if4.game_over_o; s.inv = if4.invalid_o;
      s.win = if4.winner_o; s.s1 = 4'(if4.score1_o); s.s2 = 4'(if4.score2_o);
    end else begin
      s.board = 32'(if3.board_o); s.cur = if3.cursor_o; s.turn = if3.turn_o;
      s.busy = if3.busy_o; s.over = if3.game_over_o; s.inv = if3.invalid_o;
      s.win = if3.winner_o; s.s1 = if3.score1_o; s.s2 = if3.score2_o;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s.%s: got %0h, expected %0h", tag, nm, act, exp);
  endtask

  task automatic cmp_snap(input string tag, input snap_t a, input snap_t e);
    chk(tag, "board",   a.board, e.board);
    chk(tag, "cursor",  32'(a.cur), 32'(e.cur));
    chk(tag, "turn",    32'(a.turn), 32'(e.turn));
    chk(tag, "busy",    32'(a.busy), 32'(e.busy));
    chk(tag, "over",    32'(a.over), 32'(e.over));
    chk(tag, "invalid", 32'(a.inv), 32'(e.inv));
    chk(tag, "winner",  32'(a.win), 32'(e.win));
    chk(tag, "score1",  32'(a.s1), 32'(e.s1));
    chk(tag, "score2",  32'(a.s2), 32'(e.s2));
  endtask

  task automatic edge_step(input bit d4, input bit mv, input bit sl, input bit sw, input bit ng,
                           input string tag);
    snap_t e, a;
    if (d4) begin
      if4.move_i = mv; if4.select_i = sl; if4.swap_i = sw; if4.new_game_i = ng;
    end else begin
      if3.move_i = mv; if3.select_i = sl; if3.swap_i = sw; if3.new_game_i = ng;
    end
    @(posedge clk);
    #1;
    if3.move_i = 1'b0; if3.select_i = 1'b0; if3.swap_i = 1'b0; if3.new_game_i = 1'b0;
    if4.move_i = 1'b0; if4.select_i = 1'b0; if4.swap_i = 1'b0; if4.new_game_i = 1'b0;
    a = grab(d4);
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL %s.queue: got an output cycle, expected a queued entry", tag);
    end else begin
      e = exp_q.pop_front();
      cmp_snap(tag, a, e);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    snap_t s, mid, fin;
    string tag;
    int    cells, last;
    tag   = $sformatf("v%0d", idx);
    cells = v.d4 ? 16 : 9;
    s     = st[v.d4];
    case (v.op)
      OP_MOVE: for (int k = 0; k < v.n; k++) begin
        s.cur = 4'((int'(s.cur) + 1) % cells);
        exp_q.push_back(s);
        edge_step(v.d4, 1'b1, 1'b0, 1'b0, 1'b0, tag);
      end
      OP_SWAP: begin
        s.turn = v.turn;
        exp_q.push_back(s);
        edge_step(v.d4, 1'b0, 1'b0, 1'b1, 1'b0, tag);
      end
      OP_NEW: begin
        s.board = '0; s.cur = '0; s.turn = v.turn; s.win = 2'b00; s.over = 1'b0; s.busy = 1'b0;
        exp_q.push_back(s);
        edge_step(v.d4, 1'b0, 1'b0, 1'b0, 1'b1, tag);
      end
      OP_IGN: begin
        exp_q.push_back(s);
        edge_step(v.d4, 1'b1, 1'b1, 1'b1, 1'b0, tag);
      end
      default: begin
        if (v.dec == 6) begin
          s.inv = 1'b1; exp_q.push_back(s);
          s.inv = 1'b0; exp_q.push_back(s);
          edge_step(v.d4, 1'b0, 1'b1, 1'b0, 1'b0, tag);
          edge_step(v.d4, 1'b0, 1'b0, 1'b0, 1'b0, tag);
        end else begin
          last = (v.dec < 4) ? v.dec : 3;
          mid = s; mid.board = v.board; mid.busy = 1'b1;
          exp_q.push_back(mid);
          for (int k = 0; k < last; k++) exp_q.push_back(mid);
          fin = mid; fin.busy = 1'b0; fin.turn = v.turn; fin.win = v.win;
          fin.over = (v.win != 2'b00);
          if (v.win == 2'b01) fin.s1 = v.s1;
          exp_q.push_back(fin);
          s = fin;
          edge_step(v.d4, 1'b0, 1'b1, 1'b0, 1'b0, tag);
          for (int k = 0; k <= last; k++) edge_step(v.d4, 1'b0, 1'b0, 1'b0, 1'b0, tag);
        end
      end
    endcase
    st[v.d4] = s;
  endtask

  initial begin
    snap_t s;
    zero_s = '{board: '0, cur: '0, turn: 1'b0, busy: 1'b0, over: 1'b0, inv: 1'b0,
               win: 2'b00, s1: '0, s2: '0};
    st[0] = zero_s;
    st[1] = zero_s;

    // 3x3 horizontal win: P1 at 0,1,2 and P2 at 3,4
    tbl.push_back(mk(0, OP_SEL,  0, 32'h00001, 1'b1, 2'b00, 4, 4'd0));
    tbl.push_back(mk(0, OP_MOVE, 3, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SEL,  0, 32'h00081, 1'b0, 2'b00, 4, 4'd0));
    tbl.push_back(mk(0, OP_MOVE, 7, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SEL,  0, 32'h00085, 1'b1, 2'b00, 4, 4'd0));
    tbl.push_back(mk(0, OP_MOVE, 3, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SEL,  0, 32'h00285, 1'b0, 2'b00, 4, 4'd0));
    tbl.push_back(mk(0, OP_MOVE, 7, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SEL,  0, 32'h00295, 1'b0, 2'b01, 0, SC1));
    tbl.push_back(mk(0, OP_IGN,  0, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    // new game: P2 starts; occupied-cell select
    tbl.push_back(mk(0, OP_NEW,  0, 32'h0, 1'b1, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SEL,  0, 32'h00002, 1'b0, 2'b00, 4, 4'd0));
    tbl.push_back(mk(0, OP_SEL,  0, 32'h00002, 1'b0, 2'b00, 6, 4'd0));
    // draw: X O X / X O O / O X X, filled in cell order with swaps
    tbl.push_back(mk(0, OP_NEW,  0, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SEL,  0, 32'h00001, 1'b1, 2'b00, 4, 4'd0));
    tbl.push_back(mk(0, OP_MOVE, 1, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SEL,  0, 32'h00009, 1'b0, 2'b00, 4, 4'd0));
    tbl.push_back(mk(0, OP_MOVE, 1, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SEL,  0, 32'h00019, 1'b1, 2'b00, 4, 4'd0));
    tbl.push_back(mk(0, OP_MOVE, 1, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SWAP, 0, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SEL,  0, 32'h00059, 1'b1, 2'b00, 4, 4'd0));
    tbl.push_back(mk(0, OP_MOVE, 1, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SEL,  0, 32'h00259, 1'b0, 2'b00, 4, 4'd0));
    tbl.push_back(mk(0, OP_MOVE, 1, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SWAP, 0, 32'h0, 1'b1, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SEL,  0, 32'h00A59, 1'b0, 2'b00, 4, 4'd0));
    tbl.push_back(mk(0, OP_MOVE, 1, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SWAP, 0, 32'h0, 1'b1, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SEL,  0, 32'h02A59, 1'b0, 2'b00, 4, 4'd0));
    tbl.push_back(mk(0, OP_MOVE, 1, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SEL,  0, 32'h06A59, 1'b1, 2'b00, 4, 4'd0));
    tbl.push_back(mk(0, OP_MOVE, 1, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SWAP, 0, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SEL,  0, 32'h16A59, 1'b0, 2'b11, 5, 4'd0));
    // prepare for the swap/abort sequence
    tbl.push_back(mk(0, OP_NEW,  0, 32'h0, 1'b1, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SWAP, 0, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(0, OP_SWAP, 0, 32'h0, 1'b1, 2'b00, 0, 4'd0));

    if3.move_i = 1'b0; if3.select_i = 1'b0; if3.swap_i = 1'b0; if3.new_game_i = 1'b0;
    if4.move_i = 1'b0; if4.select_i = 1'b0; if4.swap_i = 1'b0; if4.new_game_i = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_snap("reset3", grab(1'b0), zero_s);
    cmp_snap("reset4", grab(1'b1), zero_s);
    reset_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], i);

    // select by P2, then new_game sampled at E0+2 aborts the check
    s = st[0];
    s.board = 32'h2; s.busy = 1'b1;
    exp_q.push_back(s); exp_q.push_back(s);
    edge_step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "abort_sel");
    edge_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "abort_e1");
    s.board = '0; s.busy = 1'b0; s.cur = '0; s.turn = 1'b0; s.win = 2'b00; s.over = 1'b0;
    for (int k = 0; k < 5; k++) exp_q.push_back(s);
    edge_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "abort_new");
    for (int k = 0; k < 4; k++) edge_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "abort_idle");

    // all pulses at once: new_game dominates
    s.turn = 1'b1;
    exp_q.push_back(s);
    edge_step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "all_pulses");
    st[0] = s;

    // reset in the middle of a check
    s.board = 32'h2; s.busy = 1'b1;
    exp_q.push_back(s);
    edge_step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rst_sel");
    exp_q.push_back(zero_s); exp_q.push_back(zero_s);
    reset_n = 1'b0;
    edge_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid");
    reset_n = 1'b1;
    edge_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_after");
    st[0] = zero_s;
    st[1] = zero_s;

    // 4x4: anti-diagonal win by P1 at 2,5,8, then wrap and a saturating second win
    tbl.delete();
    tbl.push_back(mk(1, OP_MOVE,  2, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(1, OP_SEL,   0, 32'h00010, 1'b1, 2'b00, 4, 4'd0));
    tbl.push_back(mk(1, OP_MOVE,  1, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(1, OP_SEL,   0, 32'h00090, 1'b0, 2'b00, 4, 4'd0));
    tbl.push_back(mk(1, OP_MOVE,  2, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(1, OP_SEL,   0, 32'h00490, 1'b1, 2'b00, 4, 4'd0));
    tbl.push_back(mk(1, OP_MOVE,  1, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(1, OP_SEL,   0, 32'h02490, 1'b0, 2'b00, 4, 4'd0));
    tbl.push_back(mk(1, OP_MOVE,  2, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(1, OP_SEL,   0, 32'h12490, 1'b0, 2'b01, 3, SC1));
    tbl.push_back(mk(1, OP_NEW,   0, 32'h0, 1'b1, 2'b00, 0, 4'd0));
    tbl.push_back(mk(1, OP_MOVE, 16, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(1, OP_SWAP,  0, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(1, OP_SEL,   0, 32'h00001, 1'b1, 2'b00, 4, 4'd0));
    tbl.push_back(mk(1, OP_SWAP,  0, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(1, OP_MOVE,  1, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(1, OP_SEL,   0, 32'h00005, 1'b1, 2'b00, 4, 4'd0));
    tbl.push_back(mk(1, OP_SWAP,  0, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(1, OP_MOVE,  1, 32'h0, 1'b0, 2'b00, 0, 4'd0));
    tbl.push_back(mk(1, OP_SEL,   0, 32'h00015, 1'b0, 2'b01, 0, SC1));
    foreach (tbl[i]) run_vec(tbl[i], 100 + i);

    chk("end", "queue_left", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/board_game_core.md
# board_game_core

Parametrised N×N two-player "K-in-a-row" game engine: the generalised successor to the fixed 3×3 tic-tac-toe logic. It holds the board, the cursor, the turn and the per-player scores, and detects wins and draws with a fixed-latency directional check. It sits between the DE1_SoC key/switch front end, which delivers single-cycle edge-detected pulses, and the HEX/GPIO display drivers, which consume `board_o`, `cursor_o` and the status outputs.

## Interface
- `N`, default 3: board side; 3..8.
- `WIN_LEN`, default 3: run length that wins; 2..N.
- `SCORE_W`, default 4: width of each score counter.
- `clk` in 1: system clock (CLOCK_50 domain).
- `reset_n` in 1: synchronous, active-low reset.
- `move_i` in 1: one-cycle pulse; advance cursor.
- `select_i` in 1: one-cycle pulse; place the current player's mark at the cursor.
- `swap_i` in 1: one-cycle pulse; pass the turn without placing.
- `new_game_i` in 1: one-cycle pulse; clear the board and keep the scores.
- `cursor_o` out $clog2(N*N): cursor cell index, row-major.
- `board_o` out 2*N*N: cell i at bits [2i+1:2i]; 00 empty, 01 P1, 10 P2.
- `turn_o` out 1: 0 = P1 to move, 1 = P2.
- `busy_o` out 1: high while in CHECK.
- `game_over_o` out 1: high in OVER.
- `winner_o` out 2: 00 none, 01 P1, 10 P2, 11 draw.
- `invalid_o` out 1: one-cycle pulse when a select targets an occupied cell.
- `score1_o`, `score2_o` out SCORE_W: win counts.

## Operation
- **Reset** (`reset_n`=0 at an edge): state PLAY.
  - Board all 00, cursor 0, turn 0, start player 0.
  - winner 00, scores 0, fill count 0.
  - `invalid_o`, `busy_o` and `game_over_o` all 0.
- **States:** PLAY, CHECK (4 sub-cycles, dir 0..3 = horizontal, vertical, diagonal, anti-diagonal), OVER.
- **PLAY** evaluates inputs with priority new_game > select > swap > move.
  - select on an empty cell: write the mark, increment the fill count, go to CHECK with dir=0. Cursor is unchanged.
  - select on an occupied cell: `invalid_o` pulses for 1 cycle. Board and turn are unchanged.
  - swap: `turn_o` toggles.
  - move: cursor+1; N*N-1 wraps to 0.
- **CHECK**, one direction per cycle:
  - Run = 1 + count of consecutive same-mark cells on each side of the placed cell. Each side is bounded by the board edge and by WIN_LEN-1.
  - If run ≥ WIN_LEN: winner = turn+1, increment that score (saturating at 2^SCORE_W-1), go to OVER.
  - Else if dir=3: if fill = N*N, winner = 11 and go to OVER. Otherwise toggle turn and go to PLAY.
  - Else dir+1.
  - move, select and swap are ignored in CHECK.
- **OVER:** only new_game has effect.
- **new_game** (any state, including mid-CHECK):
  - Board cleared, cursor 0, fill 0, winner 00, state PLAY.
  - Start player toggles, and turn = new start player.
  - Scores are untouched. A CHECK aborted by new_game never scores.
- Simultaneous pulses: only the highest-priority pulse acts; the others are dropped.

## Timing
- All outputs are registered.
- Select sampled at edge E0:
  - Cell visible and `busy_o`=1 after E0.
  - Horizontal win decided at E0+1, vertical at E0+2, diagonal at E0+3, anti-diagonal at E0+4.
  - No-win turn toggle or draw at E0+4; `busy_o` falls at the same edge.
- `invalid_o` is high for exactly the cycle after the offending edge.
- move and swap take effect at the sampling edge; visible next cycle.
- `reset_n` low overrides everything, including mid-CHECK.

## Configuration
- `BOARD_GAME_SCORE_EN` defined: score counters are built as described above.
- Not defined: no score registers; `score1_o` and `score2_o` are tied to 0. Win and draw detection are unchanged.

## Test plan
- **Reset:** reset_n=0 for 2 cycles → board_o=0, cursor_o=0, turn_o=0, winner_o=00, busy_o=0.
- **Horizontal win (N=3, WIN_LEN=3):** P1 places 0,1,2 and P2 places 3,4, cursor driven by move pulses → winner_o=01 one cycle after P1's third select edge, score1_o=1, game_over_o=1; later selects ignored.
- **Occupied select:** select on a filled cell → invalid_o high exactly 1 cycle, board_o and turn_o unchanged, busy_o stays 0.
- **Draw (3×3):** fill order X,O,X,X,O,O,O,X,X by row → winner_o=11 at E0+4 after the 9th select, scores unchanged.
- **Swap then abort:** swap → turn_o=1; select, then new_game at E0+2 → board cleared, winner 00, start player toggled, no score change.
- **Anti-diagonal win (N=4, WIN_LEN=3):** P1 places 2,5,8 → winner_o=01 at E0+4 (fourth CHECK cycle); a 4×4 cursor wrap 15→0 is also checked.
